reg_sipo_frame_rx: RTL

//  Serial frame receiver; the receiving end of the PISO serial link in the register library.

---
 rtl/reg_sipo_frame_rx.sv | 111 +++++++++++
 1 files changed

// File: rtl/reg_sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Presents each good word on salida with a one-cycle dato_valido pulse; bad frames raise error pulses.
module reg_sipo_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             entrada,
    output logic [WIDTH-1:0] salida,
    output logic             dato_valido,
    output logic             err_paridad,
    output logic             err_stop,
    output logic             ocupado
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] salida_reg, salida_next;
    logic             par_reg, par_next;
    logic             perr_reg, perr_next;
    logic             dv_reg, dv_next;
    logic             pe_reg, pe_next;
    logic             se_reg, se_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            shift_reg  <= '0;
            salida_reg <= '0;
            par_reg    <= 1'b0;
            perr_reg   <= 1'b0;
            dv_reg     <= 1'b0;
            pe_reg     <= 1'b0;
            se_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            shift_reg  <= shift_next;
            salida_reg <= salida_next;
            par_reg    <= par_next;
            perr_reg   <= perr_next;
            dv_reg     <= dv_next;
            pe_reg     <= pe_next;
            se_reg     <= se_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        shift_next  = shift_reg;
        salida_next = salida_reg;
        par_next    = par_reg;
        perr_next   = perr_reg;
        dv_next     = 1'b0;
        pe_next     = 1'b0;
        se_next     = 1'b0;
        if (enable) begin
            case (state_reg)
                IDLE: begin
                    // Any sampled 0 is taken as a start bit; no glitch filtering.
                    if (!entrada) begin
                        state_next = DATA;
                        count_next = '0;
                        par_next   = 1'b0;
                        perr_next  = 1'b0;
                    end
                end
                DATA: begin
                    shift_next = {shift_reg[WIDTH-2:0], entrada};
                    par_next   = par_reg ^ entrada;
                    count_next = count_reg + CW'(1);
                    if (count_reg == LAST_BIT) begin
                        if (PARITY_EN) state_next = PARITY;
                        else           state_next = STOP;
                    end
                end
                PARITY: begin
                    perr_next  = par_reg ^ entrada;
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (entrada && !perr_reg) begin
                        salida_next = shift_reg;
                        dv_next     = 1'b1;
                    end
                    se_next = !entrada;
                    pe_next = perr_reg;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign salida      = salida_reg;
    assign dato_valido = dv_reg;
    assign err_paridad = pe_reg;
    assign err_stop    = se_reg;
    assign ocupado     = (state_reg != IDLE);

endmodule
